error_weight_scheduler: RTL

ERROR_WEIGHT_SCHEDULER -- requirements
Module: error_weight_scheduler

---
 rtl/error_weight_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/error_weight_scheduler.sv
// Phase-error driven loop-state scheduler: tracks acquisition/lock quality and selects combiner weights.
// Optional build macro LOCK_LOSS_FILTER_EN requires LOSS_SAMPLES consecutive bad samples before dropping lock.
module error_weight_scheduler #(
    parameter int ERROR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 3,
    parameter int ACQ_THRESH   = 16,
    parameter int LOCK_THRESH  = 4,
    parameter int ACQ_SAMPLES  = 8,
    parameter int LOCK_SAMPLES = 16,
    parameter int LOSS_SAMPLES = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic                           error_valid_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_comb_i,
    output logic [WEIGHT_WIDTH-1:0]        weight_0_o,
    output logic [WEIGHT_WIDTH-1:0]        weight_1_o,
    output logic [WEIGHT_WIDTH-1:0]        weight_2_o,
    output logic [WEIGHT_WIDTH-1:0]        weight_3_o,
    output logic [1:0]                     state_o,
    output logic                           locked_o,
    output logic                           lock_lost_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int MAX_AL  = (ACQ_SAMPLES > LOCK_SAMPLES) ? ACQ_SAMPLES : LOCK_SAMPLES;
    localparam int MAX_CNT = (MAX_AL > LOSS_SAMPLES) ? MAX_AL : LOSS_SAMPLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]       ACQ_N  = CNT_W'(ACQ_SAMPLES);
    localparam logic [CNT_W-1:0]       LOCK_N = CNT_W'(LOCK_SAMPLES);
    localparam logic [ERROR_WIDTH-1:0] ACQ_T  = ERROR_WIDTH'(ACQ_THRESH);
    localparam logic [ERROR_WIDTH-1:0] LOCK_T = ERROR_WIDTH'(LOCK_THRESH);
`ifdef LOCK_LOSS_FILTER_EN
    localparam logic [CNT_W-1:0]       LOSS_N = CNT_W'(LOSS_SAMPLES);
`endif

    localparam logic [ERROR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d, cnt_inc;
    logic [3:0][WEIGHT_WIDTH-1:0]       w_q, w_d;
    logic                               locked_q, lost_q, lost_d;
    logic [ERROR_WIDTH-1:0]             err_mag;
    logic                               in_acq, in_lock;

    // Most negative code has no positive twin; clamp it to the largest magnitude.
    always_comb begin
        if (error_comb_i == ERR_MIN)
            err_mag = ERR_MAX;
        else if (error_comb_i[ERROR_WIDTH-1])
            err_mag = -error_comb_i;
        else
            err_mag = error_comb_i;
    end

    assign in_acq  = (err_mag <= ACQ_T);
    assign in_lock = (err_mag <= LOCK_T);
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
                ACQUIRE: if (error_valid_i) begin
                    if (!in_acq) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= ACQ_N) begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                TRACK: if (error_valid_i) begin
                    if (!in_acq) begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end else if (!in_lock) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= LOCK_N) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOCKED: if (error_valid_i) begin
`ifdef LOCK_LOSS_FILTER_EN
                    // In LOCKED the run counter counts consecutive out-of-window samples.
                    if (in_acq) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= LOSS_N) begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    if (!in_acq) begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_d = '0;
        case (state_d)
            ACQUIRE: w_d = {WEIGHT_WIDTH'(4), WEIGHT_WIDTH'(4), WEIGHT_WIDTH'(0), WEIGHT_WIDTH'(0)};
            TRACK:   w_d = {WEIGHT_WIDTH'(2), WEIGHT_WIDTH'(2), WEIGHT_WIDTH'(2), WEIGHT_WIDTH'(2)};
            LOCKED:  w_d = {WEIGHT_WIDTH'(1), WEIGHT_WIDTH'(1), WEIGHT_WIDTH'(1), WEIGHT_WIDTH'(1)};
            default: w_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            w_q      <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            locked_q <= (state_d == LOCKED);
            lost_q   <= lost_d;
        end
    end

    assign weight_0_o  = w_q[3];
    assign weight_1_o  = w_q[2];
    assign weight_2_o  = w_q[1];
    assign weight_3_o  = w_q[0];
    assign state_o     = state_q;
    assign locked_o    = locked_q;
    assign lock_lost_o = lost_q;

endmodule
